// File: rtl/prog_cntr_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// prog_cntr_sel_ctrl_if
//   Bundles the control events going into the fetch-stage PC-select
//   controller and the mux-select / strobe outputs coming back from it.
//
//   Event signalling: branch_taken and ret_req are single-cycle pulses with
//   no backpressure. The only flow control is stall, which blocks PC loads
//   while high. The controller remembers events that arrive during a stall.
//   int_req is a level and is sampled every cycle.
//
//   Modports:
//     master : the decode/execute side (drives events, observes outputs)
//     slave  : the controller itself
//
//   Signals:
//     stall, branch_taken, ret_req, reti, int_req, int_en   (master -> slave)
//     sel_signals[3:0], pc_load_en, flush_fetch, int_ack,
//     ret_addr_push, int_active                             (slave -> master)
//     dbg_state[1:0], dbg_pend_branch, dbg_pend_ret,
//     dbg_pend_reti                                         (slave -> master)
// ---------------------------------------------------------------------------
interface prog_cntr_sel_ctrl_if;
    logic       stall;
    logic       branch_taken;
    logic       ret_req;
    logic       reti;
    logic       int_req;
    logic       int_en;

    logic [3:0] sel_signals;
    logic       pc_load_en;
    logic       flush_fetch;
    logic       int_ack;
    logic       ret_addr_push;
    logic       int_active;

    // Internal state exposed for observation only.
    logic [1:0] dbg_state;
    logic       dbg_pend_branch;
    logic       dbg_pend_ret;
    logic       dbg_pend_reti;

    modport master (
        output stall, branch_taken, ret_req, reti, int_req, int_en,
        input  sel_signals, pc_load_en, flush_fetch, int_ack,
               ret_addr_push, int_active,
               dbg_state, dbg_pend_branch, dbg_pend_ret, dbg_pend_reti
    );

    modport slave (
        input  stall, branch_taken, ret_req, reti, int_req, int_en,
        output sel_signals, pc_load_en, flush_fetch, int_ack,
               ret_addr_push, int_active,
               dbg_state, dbg_pend_branch, dbg_pend_ret, dbg_pend_reti
    );
endinterface

// File: rtl/prog_cntr_sel_ctrl.sv
// ---------------------------------------------------------------------------
// prog_cntr_sel_ctrl
//   Fetch-stage controller for the program-counter load mux. It chooses
//   between sequential fetch, taken branches, returns and interrupt entry.
//   It holds the PC during stalls, and remembers branch and return events
//   that arrive while the PC is held. Before it vectors to an interrupt, it
//   holds the PC for DRAIN_CYCLES cycles so that in-flight instructions can
//   resolve.
//
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : prog_cntr_sel_ctrl_if.slave
//       sel_signals one-hot select: bit0 branch target, bit1 next PC,
//                   bit2 interrupt vector, bit3 return address,
//                   0000 selects address 0
//
//   Parameters:
//     DRAIN_CYCLES : hold cycles before an interrupt jump (1..2^CNT_W-1)
//     CNT_W        : drain counter width
// ---------------------------------------------------------------------------
module prog_cntr_sel_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    prog_cntr_sel_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] SEL_ZERO   = 4'b0000;
    localparam logic [3:0] SEL_BRANCH = 4'b0001;
    localparam logic [3:0] SEL_NEXT   = 4'b0010;
    localparam logic [3:0] SEL_VECTOR = 4'b0100;
    localparam logic [3:0] SEL_RET    = 4'b1000;

    // Counter value loaded when a drain starts or restarts. A counter value
    // of zero means that the next event-free cycle performs the jump.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    logic             r_pend_branch;
    logic             r_pend_ret;
    logic             r_pend_reti;
    logic             r_int_active;
    logic [CNT_W-1:0] r_cnt;

    logic             w_branch;
    logic             w_ret;
    logic             w_is_reti;
    logic             w_int_ok;
    logic             w_take_int;
    logic             w_cnt_zero;
    logic             w_latch_ret;

    // A branch outranks a return. A live branch also outranks a pending
    // return, and a return that arrives in the same cycle as a branch is
    // dropped.
    assign w_branch    = bus.branch_taken | r_pend_branch;
    assign w_ret       = bus.ret_req | r_pend_ret;
    assign w_is_reti   = bus.ret_req ? bus.reti : r_pend_reti;
    assign w_int_ok    = bus.int_req & bus.int_en;
    assign w_take_int  = w_int_ok & ~r_int_active;
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_latch_ret = bus.ret_req & ~bus.branch_taken;

    // ------------------------------------------------------------------
    // Outputs: combinational from the registered state and the current
    // inputs. While reset is asserted, every strobe is forced low.
    // ------------------------------------------------------------------
    always_comb begin
        bus.sel_signals   = SEL_NEXT;
        bus.pc_load_en    = 1'b0;
        bus.flush_fetch   = 1'b0;
        bus.int_ack       = 1'b0;
        bus.ret_addr_push = 1'b0;
        if (reset) begin
            bus.sel_signals = SEL_ZERO;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    bus.sel_signals = SEL_ZERO;
                    bus.pc_load_en  = 1'b1;
                    bus.flush_fetch = 1'b1;
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (w_branch) begin
                            bus.sel_signals = SEL_BRANCH;
                            bus.pc_load_en  = 1'b1;
                            bus.flush_fetch = 1'b1;
                        end else if (w_ret) begin
                            bus.sel_signals = SEL_RET;
                            bus.pc_load_en  = 1'b1;
                            bus.flush_fetch = 1'b1;
                        end else if (!w_take_int) begin
                            bus.pc_load_en = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!bus.stall) begin
                        if (w_branch) begin
                            bus.sel_signals = SEL_BRANCH;
                            bus.pc_load_en  = 1'b1;
                            bus.flush_fetch = 1'b1;
                        end else if (w_ret) begin
                            bus.sel_signals = SEL_RET;
                            bus.pc_load_en  = 1'b1;
                            bus.flush_fetch = 1'b1;
                        end else if (w_cnt_zero) begin
                            bus.sel_signals   = SEL_VECTOR;
                            bus.pc_load_en    = 1'b1;
                            bus.flush_fetch   = 1'b1;
                            bus.int_ack       = 1'b1;
                            bus.ret_addr_push = 1'b1;
                        end
                    end
                end
                default: begin
                    bus.sel_signals = SEL_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, pending events, interrupt-active flag and drain counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pend_branch <= 1'b0;
            r_pend_ret    <= 1'b0;
            r_pend_reti   <= 1'b0;
            r_int_active  <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end

                ST_RUN: begin
                    if (bus.stall) begin
                        if (bus.branch_taken) r_pend_branch <= 1'b1;
                        if (w_latch_ret) begin
                            r_pend_ret  <= 1'b1;
                            r_pend_reti <= bus.reti;
                        end
                    end else if (w_branch) begin
                        r_pend_branch <= 1'b0;
                        r_pend_ret    <= 1'b0;
                        r_pend_reti   <= 1'b0;
                    end else if (w_ret) begin
                        r_pend_ret  <= 1'b0;
                        r_pend_reti <= 1'b0;
                        if (w_is_reti) r_int_active <= 1'b0;
                    end else if (w_take_int) begin
                        r_cnt   <= CNT_RELOAD;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (bus.stall) begin
                        // Hold the counter and remember the events.
                        if (bus.branch_taken) r_pend_branch <= 1'b1;
                        if (w_latch_ret) begin
                            r_pend_ret  <= 1'b1;
                            r_pend_reti <= bus.reti;
                        end
                    end else if (w_branch) begin
                        // The redirect creates new in-flight work, so the
                        // drain starts again.
                        r_pend_branch <= 1'b0;
                        r_pend_ret    <= 1'b0;
                        r_pend_reti   <= 1'b0;
                        r_cnt         <= CNT_RELOAD;
                    end else if (w_ret) begin
                        r_pend_ret  <= 1'b0;
                        r_pend_reti <= 1'b0;
                        if (w_is_reti) r_int_active <= 1'b0;
                        r_cnt <= CNT_RELOAD;
                    end else if (!w_cnt_zero) begin
                        // If the request is withdrawn mid-drain, abandon the
                        // entry without jumping.
                        if (!w_int_ok) r_state <= ST_RUN;
                        else           r_cnt   <= r_cnt - CNT_W'(1);
                    end else begin
                        r_int_active <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.int_active      = r_int_active;
    assign bus.dbg_state       = r_state;
    assign bus.dbg_pend_branch = r_pend_branch;
    assign bus.dbg_pend_ret    = r_pend_ret;
    assign bus.dbg_pend_reti   = r_pend_reti;

endmodule
